// File: rtl/spike_integrator_pkg.sv
// Shared neuron definitions: state encoding, membrane width derivation and
// saturation bounds, plus the widths spike_generator builds its ports from.
package spike_integrator_pkg;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } neuron_state_t;

  localparam int DEFAULT_N_STAGE = 2;
  localparam int LEAK_SHIFT_W    = 3;
  localparam int REFRAC_W        = 4;

  // Membrane potential width for a given stage count.
  function automatic int membrane_width(input int n_stage);
    return n_stage + 2;
  endfunction

  // Largest value representable in a w-bit two's complement membrane.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's complement membrane.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // spike_generator sizes its u port with membrane_width(), so the
  // integrator's u connects to it with no width adaptation.
  localparam int GEN_U_W = membrane_width(DEFAULT_N_STAGE);

endpackage

// File: rtl/spike_integrator_synapse_sum.sv
// Combinational weighted adder: sums the weights of every synapse that spiked,
// sign-extended to a width wide enough that no partial sum can overflow.
module synapse_sum
  import spike_integrator_pkg::*;
#(
  parameter int W     = 4,
  parameter int N_IN  = 4,
  parameter int SUM_W = W + $clog2(N_IN) + 1
) (
  input  logic [N_IN-1:0]         spikes_in,
  input  logic [N_IN*W-1:0]       weights,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [W-1:0] weight_i;

  // Accumulate the sign-extended weight of each active synapse.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned, which would infer a latch.
    sum      = '0;
    weight_i = '0;
    for (int i = 0; i < N_IN; i++) begin
      weight_i = weights[i*W +: W];
      if (spikes_in[i]) begin
        sum = sum + SUM_W'(weight_i);
      end
    end
  end

endmodule

// File: rtl/spike_integrator.sv
// Leaky integrate-and-fire membrane: integrates weighted input spikes with an
// arithmetic-shift leak and saturation, then holds at zero for a programmable
// refractory period after each fire.
module spike_integrator
  import spike_integrator_pkg::*;
#(
  parameter  int N_STAGE = DEFAULT_N_STAGE,
  parameter  int N_IN    = 4,
  localparam int W       = membrane_width(N_STAGE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_IN-1:0]         spikes_in,
  input  logic [N_IN*W-1:0]       weights,
  input  logic [LEAK_SHIFT_W-1:0] leak_shift,
  input  logic [REFRAC_W-1:0]     refrac_len,
  input  logic                    is_spike,
  output logic signed [W-1:0]     u,
  output logic                    refractory
);

  localparam int SUM_W = W + $clog2(N_IN) + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(W));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(W));

  neuron_state_t         state_q, state_n;
  logic [REFRAC_W-1:0]   count_q, count_n;
  logic signed [W-1:0]   u_q, u_n;

  logic signed [SUM_W-1:0] syn_sum;
  logic signed [W-1:0]     leak;
  logic signed [SUM_W-1:0] pre_sat;
  logic signed [W-1:0]     u_sat;

  synapse_sum #(
    .W    (W),
    .N_IN (N_IN),
    .SUM_W(SUM_W)
  ) u_synapse_sum (
    .spikes_in(spikes_in),
    .weights  (weights),
    .sum      (syn_sum)
  );

  // Leak, integration and clamp to the membrane range.
  always_comb begin
    leak = '0;
    if (leak_shift != '0) begin
      leak = u_q >>> leak_shift;
    end
    pre_sat = SUM_W'(u_q) - SUM_W'(leak) + syn_sum;
    if (pre_sat > SAT_HI) begin
      u_sat = SAT_HI[W-1:0];
    end else if (pre_sat < SAT_LO) begin
      u_sat = SAT_LO[W-1:0];
    end else begin
      u_sat = pre_sat[W-1:0];
    end
  end

  // Next-state logic: fire entry, refractory countdown, and stall when disabled.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    u_n     = u_q;
    if (en) begin
      unique case (state_q)
        ST_INTEGRATE: begin
          if (is_spike) begin
            // Fire: incoming spikes this cycle are dropped; refrac_len is
            // captured only here.
            u_n     = '0;
            count_n = refrac_len;
            state_n = (refrac_len != '0) ? ST_REFRACT : ST_INTEGRATE;
          end else begin
            u_n = u_sat;
          end
        end
        ST_REFRACT: begin
          u_n     = '0;
          count_n = count_q - 1'b1;
          if (count_q <= REFRAC_W'(1)) begin
            state_n = ST_INTEGRATE;
          end
        end
        default: begin
          state_n = ST_INTEGRATE;
        end
      endcase
    end
  end

  // State, counter and membrane registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_INTEGRATE;
      count_q <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      u_q     <= u_n;
    end
  end

  assign u          = u_q;
  assign refractory = (state_q == ST_REFRACT);

endmodule

// File: tb/tb_spike_integrator.sv
// Directed bench for spike_integrator at N_STAGE=2 (W=4, range -8..7), N_IN=4.
module tb_spike_integrator;

  localparam int W    = 4;
  localparam int N_IN = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [N_IN-1:0]     spikes_in;
  logic [N_IN*W-1:0]   weights;
  logic [2:0]          leak_shift;
  logic [3:0]          refrac_len;
  logic                is_spike;
  logic signed [W-1:0] u;
  logic                refractory;

  int total = 0;
  int bad   = 0;

  spike_integrator #(
    .N_STAGE(2),
    .N_IN   (N_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spikes_in (spikes_in),
    .weights   (weights),
    .leak_shift(leak_shift),
    .refrac_len(refrac_len),
    .is_spike  (is_spike),
    .u         (u),
    .refractory(refractory)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input logic signed [W-1:0] w0, input logic signed [W-1:0] w1,
                             input logic signed [W-1:0] w2, input logic signed [W-1:0] w3);
    weights = {w3, w2, w1, w0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rst        = 1'b1;
      en         = 1'($urandom);
      spikes_in  = 4'($urandom);
      weights    = 16'($urandom);
      leak_shift = 3'($urandom);
      refrac_len = 4'($urandom);
      is_spike   = 1'($urandom);
      tick();
      total++;
      if (u !== 4'sd0 || refractory !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: u=%0d refractory=%b, expected u=0 refractory=0", c, u, refractory);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pos_sat();
    logic signed [W-1:0] exp_u [3] = '{4'sd5, 4'sd7, 4'sd7};
    do_reset();
    en = 1'b1; is_spike = 1'b0; leak_shift = 3'd0; refrac_len = 4'd0;
    set_weights(4'sd3, 4'sd2, 4'sd7, -4'sd8);  // w2/w3 must be masked off
    spikes_in = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (u !== exp_u[c] || refractory !== 1'b0) begin
        bad++;
        $display("FAIL pos_sat[%0d]: u=%0d refr=%b, expected u=%0d refr=0", c, u, refractory, exp_u[c]);
      end
    end
  endtask

  // u - (u >>> 1) from -8: -8+4=-4, -4+2=-2, -2+1=-1, -1+1=0.
  task automatic test_neg_sat_leak();
    logic signed [W-1:0] exp_u [7] = '{-4'sd5, -4'sd8, -4'sd8, -4'sd4, -4'sd2, -4'sd1, 4'sd0};
    do_reset();
    en = 1'b1; is_spike = 1'b0; leak_shift = 3'd0;
    set_weights(-4'sd5, 4'sd7, 4'sd7, 4'sd7);
    spikes_in = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin
        spikes_in  = 4'b0000;
        leak_shift = 3'd1;
      end
      tick();
      total++;
      if (u !== exp_u[c]) begin
        bad++;
        $display("FAIL neg_sat_leak[%0d]: u=%0d, expected %0d", c, u, exp_u[c]);
      end
    end
  endtask

  // u - (u >>> 1) from 7: 7-3=4, 4-2=2, 2-1=1, 1-0=1.
  task automatic test_pos_leak();
    logic signed [W-1:0] exp_u [4] = '{4'sd4, 4'sd2, 4'sd1, 4'sd1};
    do_reset();
    en = 1'b1; is_spike = 1'b0; leak_shift = 3'd0;
    set_weights(4'sd3, 4'sd2, 4'sd0, 4'sd0);
    spikes_in = 4'b0011;
    tick(); tick();
    total++;
    if (u !== 4'sd7) begin
      bad++;
      $display("FAIL pos_leak_setup: u=%0d, expected 7", u);
    end
    spikes_in  = 4'b0000;
    leak_shift = 3'd1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (u !== exp_u[c]) begin
        bad++;
        $display("FAIL pos_leak[%0d]: u=%0d, expected %0d", c, u, exp_u[c]);
      end
    end
  endtask

  // Mixed-sign sums through the wide adder: 7-8+3-1=1; 1-8-1=-8 (clamped); -8+7+3=2.
  task automatic test_mixed_sum();
    logic [N_IN-1:0]     pat   [3] = '{4'b1111, 4'b1010, 4'b0101};
    logic signed [W-1:0] exp_u [3] = '{4'sd1, -4'sd8, 4'sd2};
    do_reset();
    en = 1'b1; is_spike = 1'b0; leak_shift = 3'd0;
    set_weights(4'sd7, -4'sd8, 4'sd3, -4'sd1);
    for (int c = 0; c < 3; c++) begin
      spikes_in = pat[c];
      tick();
      total++;
      if (u !== exp_u[c]) begin
        bad++;
        $display("FAIL mixed_sum[%0d]: u=%0d, expected %0d", c, u, exp_u[c]);
      end
    end
  endtask

  task automatic test_fire_refractory();
    logic signed [W-1:0] exp_u [6] = '{4'sd0, 4'sd0, 4'sd0, 4'sd4, 4'sd0, 4'sd4};
    logic                exp_r [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    en = 1'b1; leak_shift = 3'd0;
    set_weights(4'sd1, 4'sd1, 4'sd1, 4'sd1);
    spikes_in  = 4'b1111;
    refrac_len = 4'd2;
    is_spike   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) refrac_len = 4'd9;     // ignored mid-refractory
      if (c == 3) is_spike = 1'b0;       // resume integration: 0 + 4
      if (c == 4) begin                  // fire with zero refractory length
        refrac_len = 4'd0;
        is_spike   = 1'b1;
      end
      if (c == 5) is_spike = 1'b0;
      tick();
      total++;
      if (u !== exp_u[c] || refractory !== exp_r[c]) begin
        bad++;
        $display("FAIL fire[%0d]: u=%0d refr=%b, expected u=%0d refr=%b",
                 c, u, refractory, exp_u[c], exp_r[c]);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    // Disabled in INTEGRATE: u holds and is_spike is ignored.
    do_reset();
    en = 1'b1; is_spike = 1'b0; leak_shift = 3'd0;
    set_weights(4'sd1, 4'sd1, 4'sd1, 4'sd1);
    spikes_in = 4'b1111;
    tick();
    en = 1'b0; is_spike = 1'b1;
    tick();
    total++;
    if (u !== 4'sd4 || refractory !== 1'b0) begin
      bad++;
      $display("FAIL stall_integrate: u=%0d refr=%b, expected u=4 refr=0", u, refractory);
    end
    // Fire with refrac_len=3, stall 4 cycles, then 3 enabled cycles of refractory.
    en = 1'b1; refrac_len = 4'd3;
    tick();
    is_spike = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (refractory !== (c < 7) || u !== 4'sd0) begin
        bad++;
        $display("FAIL stall_refract[%0d]: u=%0d refr=%b, expected u=0 refr=%b", c, u, refractory, c < 7);
      end
      en = (c >= 4);
      tick();
    end
    // Reset in the middle of a refractory period, then integrate normally.
    refrac_len = 4'd5; is_spike = 1'b1; en = 1'b1;
    tick();
    total++;
    if (refractory !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_setup: refr=%b, expected 1", refractory);
    end
    rst = 1'b1;
    tick();
    total++;
    if (u !== 4'sd0 || refractory !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: u=%0d refr=%b, expected u=0 refr=0", u, refractory);
    end
    rst = 1'b0; is_spike = 1'b0; spikes_in = 4'b0001;
    tick();
    total++;
    if (u !== 4'sd1 || refractory !== 1'b0) begin
      bad++;
      $display("FAIL rst_resume: u=%0d refr=%b, expected u=1 refr=0", u, refractory);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spikes_in = '0; weights = '0;
    leak_shift = '0; refrac_len = '0; is_spike = 1'b0;
    tick();
    test_reset();
    test_pos_sat();
    test_neg_sat_leak();
    test_pos_leak();
    test_mixed_sum();
    test_fire_refractory();
    test_stall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
